// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if
//   Bundles the request/grant signals between the requesting units and the
//   4-way arbiter.
//   master : requester side  - drives ein, req, done; observes grant outputs
//   slave  : arbiter side    - observes ein, req, done; drives grant outputs
//   Signals:
//     ein      1  arbiter enable
//     req      4  request vector, bit i = requester i
//     done     1  current owner releases the resource
//     gnt      4  one-hot grant (0 when no owner)
//     gnt_id   2  index of the granted requester (0 when no owner)
//     gs       1  group select, high while a grant is active
//     eout     1  enable-out for chaining when idle with no requests
//     timeout  1  one-cycle pulse after a hold-limit forced release
interface rr_arbiter4_if;
  logic       ein;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gs;
  logic       eout;
  logic       timeout;

  modport master (
    output ein, req, done,
    input  gnt, gnt_id, gs, eout, timeout
  );

  modport slave (
    input  ein, req, done,
    output gnt, gnt_id, gs, eout, timeout
  );
endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4
//   Sequential 4-requester arbiter for one shared resource. A grant is issued
//   one cycle after a request is seen in IDLE, held until the owner releases
//   (done, dropped request, enable removed) or the hold limit expires, and is
//   always followed by one dead cycle. Winners rotate round-robin from a
//   pointer that advances past the last owner.
//   Ports:
//     clk   in  clock, rising edge
//     rst   in  synchronous active-high reset
//     bus   rr_arbiter4_if.slave (ein, req, done in; gnt, gnt_id, gs, eout,
//           timeout out)
//   Parameters:
//     HOLD_MAX  max consecutive grant cycles (0 = unlimited)
//     CNT_W     hold counter width, 2**CNT_W > HOLD_MAX
//   Build option:
//     FIXED_PRIO_EN  when defined, the highest set request index always wins
//                    and the round-robin pointer is not built.
module rr_arbiter4 #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter4_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eout_q, eout_d;
  logic             timeout_q, timeout_d;

  logic [1:0] win_id;
  logic       any_req;
  logic       owner_req;
  logic       hold_hit;
  logic       release_now;

  assign any_req   = |bus.req;
  assign owner_req = bus.req[gnt_id_q];
  // cnt counts completed grant cycles minus one, so the last allowed cycle
  // is the one where cnt reaches HOLD_MAX-1.
  assign hold_hit    = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign release_now = bus.done | ~owner_req | ~bus.ein | hold_hit;

`ifdef FIXED_PRIO_EN
  // Highest set index wins; later loop iterations override earlier ones.
  always_comb begin
    win_id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.req[i]) win_id = 2'(i);
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] req_rot;
  logic [1:0] rot_off;

  // Rotate the request vector so bit 0 is the requester at the pointer;
  // the 2-bit index sum wraps 3 -> 0 naturally.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign req_rot[gi] = bus.req[ptr_q + 2'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the first requester after ptr.
  always_comb begin
    rot_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_rot[i]) rot_off = 2'(i);
    end
    win_id = ptr_q + rot_off;
  end

  // Advance past the releasing owner; an enable abort keeps the pointer so
  // the interrupted requester is not penalised.
  always_comb begin
    ptr_d = ptr_q;
    if ((state_q == ST_GRANT) && release_now && bus.ein) begin
      ptr_d = gnt_id_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    cnt_d     = cnt_q;
    eout_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.ein && any_req) begin
          state_d  = ST_GRANT;
          gnt_d    = 4'b0001 << win_id;
          gnt_id_d = win_id;
          cnt_d    = '0;
        end else begin
          eout_d = bus.ein & ~any_req;
        end
      end
      default: begin
        if (release_now) begin
          state_d  = ST_IDLE;
          gnt_d    = 4'b0000;
          gnt_id_d = 2'd0;
          cnt_d    = '0;
          // A voluntary release (done, dropped request) in the same edge
          // as the hold limit is not reported as a timeout.
          timeout_d = hold_hit & ~bus.done & owner_req;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      cnt_q     <= '0;
      eout_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      cnt_q     <= cnt_d;
      eout_q    <= eout_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gs      = (state_q == ST_GRANT);
  assign bus.eout    = eout_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4
//   Drives directed and random stimulus on the falling edge, advances a
//   behavioural model of the arbiter for the coming rising edge and queues
//   the expected outputs; a separate monitor pops and compares every cycle.
module tb_rr_arbiter4;
  localparam int HOLD = 8;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gs;
    logic       eout;
    logic       timeout;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  rr_arbiter4_if bus_if();

  rr_arbiter4 #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  outs_t exp_q[$];
  int    checks = 0;
  int    passed = 0;
  bit    started = 1'b0;
  int    cyc = 0;

  // Model state: owner index (-1 = none), cycles held so far, rotation start.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  bit m_eout  = 1'b0;
  bit m_to    = 1'b0;

  function automatic int pick(input int ptr, input bit [3:0] rq);
`ifdef FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) if (rq[i]) return i;
`else
    for (int k = 0; k < 4; k++) if (rq[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
    return 0;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit [3:0] rq, input bit d);
    outs_t o;
    bit forced;
    if (r) begin
      m_owner = -1; m_held = 0; m_ptr = 0; m_eout = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      if (e && rq != 4'b0) begin
        m_owner = pick(m_ptr, rq);
        m_held  = 1;
        m_eout  = 0;
      end else begin
        m_eout = e && (rq == 4'b0);
      end
    end else begin
      m_eout = 0;
      forced = (HOLD != 0) && (m_held == HOLD);
      if (d || !rq[m_owner] || !e || forced) begin
        m_to = forced && !d && rq[m_owner];
        if (e) m_ptr = (m_owner + 1) % 4;
        m_owner = -1;
        m_held  = 0;
      end else begin
        m_to = 0;
        m_held++;
      end
    end
    o.gnt     = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    o.gnt_id  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    o.gs      = (m_owner >= 0);
    o.eout    = m_eout;
    o.timeout = m_to;
    exp_q.push_back(o);
  endtask

  task automatic cycle(input bit r, input bit e, input bit [3:0] rq, input bit d);
    @(negedge clk);
    rst = r;
    bus_if.ein  = e;
    bus_if.req  = rq;
    bus_if.done = d;
    model_step(r, e, rq, d);
    started = 1'b1;
  endtask

  // Monitor: one comparison per rising edge.
  initial begin
    outs_t act, expv;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        cyc++;
        act = {bus_if.gnt, bus_if.gnt_id, bus_if.gs, bus_if.eout, bus_if.timeout};
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL cyc%0d scoreboard_empty actual gnt=%b id=%0d gs=%b eout=%b to=%b required=none",
                   cyc, act.gnt, act.gnt_id, act.gs, act.eout, act.timeout);
        end else begin
          expv = exp_q.pop_front();
          if (act !== expv) begin
            $display("FAIL cyc%0d outputs actual gnt=%b id=%0d gs=%b eout=%b to=%b required gnt=%b id=%0d gs=%b eout=%b to=%b",
                     cyc, act.gnt, act.gnt_id, act.gs, act.eout, act.timeout,
                     expv.gnt, expv.gnt_id, expv.gs, expv.eout, expv.timeout);
          end else begin
            passed++;
            $display("cyc%0d ok gnt=%b id=%0d gs=%b eout=%b to=%b",
                     cyc, act.gnt, act.gnt_id, act.gs, act.eout, act.timeout);
          end
        end
      end
    end
  end

  initial begin
    bus_if.ein  = 1'b1;
    bus_if.req  = 4'hF;
    bus_if.done = 1'b0;

    // Reset held two cycles with all requests up, then first grant to 0.
    cycle(1, 1, 4'hF, 0);
    cycle(1, 1, 4'hF, 0);
    cycle(0, 1, 4'hF, 0);
    cycle(0, 0, 4'h0, 0);
    cycle(0, 0, 4'h0, 0);

    // Single requester 2, done on third grant cycle; then all request -> 3 next.
    cycle(0, 1, 4'b0100, 0);
    cycle(0, 1, 4'b0100, 0);
    cycle(0, 1, 4'b0100, 0);
    cycle(0, 1, 4'b0100, 1);
    cycle(0, 1, 4'b0000, 0);

    // All request, done every second grant cycle: rotation with dead cycles.
    for (int i = 0; i < 16; i++) cycle(0, 1, 4'hF, (i % 3) == 2);

    // Single requester held with no done: forced release and timeout pulse.
    cycle(0, 1, 4'b0000, 0);
    for (int i = 0; i < 22; i++) cycle(0, 1, 4'b0010, 0);

    // Grant on 2 aborted by ein=0, then idle enable-out.
    cycle(0, 1, 4'b0000, 0);
    cycle(0, 1, 4'b0100, 0);
    cycle(0, 1, 4'b0100, 0);
    cycle(0, 0, 4'b0100, 0);
    cycle(0, 1, 4'b0000, 0);
    cycle(0, 1, 4'b0000, 0);
    cycle(0, 1, 4'hF, 0);
    cycle(0, 1, 4'hF, 1);

    // Mid-grant reset.
    cycle(0, 1, 4'b1000, 0);
    cycle(0, 1, 4'b1000, 0);
    cycle(1, 1, 4'b1000, 0);
    cycle(0, 1, 4'b0000, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit r, e, d;
      bit [3:0] rq;
      r  = ($urandom_range(0, 63) == 0);
      e  = ($urandom_range(0, 7) != 0);
      rq = ($urandom_range(0, 5) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 5) == 0);
      cycle(r, e, rq, d);
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL leftover_expectations actual=%0d required=0", exp_q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
